button_debouncer: RTL and testbench
===================================

# button_debouncer

Board-facing conditioning stage for a mechanical push-button: synchronizes the raw pin, filters contact bounce with a stability counter, and produces a clean level plus single-cycle press/release (and optional long-press) pulses. Sits between the board button pins and the design's clock/reset generator and user logic. Runs in the design clock domain and takes the generator's `resetn`.

## Interface
- `ACTIVE_LOW`, 1: raw pin polarity; 1 = pressed reads 0 (board default), 0 = pressed reads 1.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a change (10 ms at 50 MHz); legal range ≥ 2.
- `LONG_CYCLES`, 50000000: cycles held in PRESSED before `btn_long` fires (1 s at 50 MHz); legal range ≥ 2.
- `CNT_W`, `$clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES))`: counter width, derived; not overridden.

Ports:
- `clk` in 1: design clock; single clock domain.
- `resetn` in 1: asynchronous, active-low reset.
- `btn_raw` in 1: asynchronous pin from the board.
- `btn_level` out 1: debounced, active-high pressed state.
- `btn_press` out 1: one-cycle pulse on accepted press.
- `btn_release` out 1: one-cycle pulse on accepted release.
- `btn_long` out 1: one-cycle pulse once per press after `LONG_CYCLES` held.

## Operation
- Input path:
  - Two-flop synchronizer on `btn_raw`; both flops reset to the released level (`ACTIVE_LOW`).
  - The synchronized value is normalized to active-high `s`.
- FSM states and transitions:
  - IDLE: `s=1` → PRESS_WAIT, `cnt←0`.
  - PRESS_WAIT:
    - `s=0` → IDLE (bounce; nothing emitted).
    - Else `cnt++`.
    - When `cnt==DEBOUNCE_CYCLES-1` and `s=1` → PRESSED: `btn_level←1`, `btn_press` pulse, long counter `←0`.
  - PRESSED: `s=0` → RELEASE_WAIT, `cnt←0`.
  - RELEASE_WAIT:
    - `s=1` → PRESSED (bounce; nothing emitted; long counter keeps running, not cleared).
    - Else `cnt++`.
    - When `cnt==DEBOUNCE_CYCLES-1` → IDLE: `btn_level←0`, `btn_release` pulse.
- Counters:
  - `cnt` and the long counter are unsigned `CNT_W` bits.
  - Neither ever wraps: `cnt` is bounded by the FSM.
  - The long counter saturates at `LONG_CYCLES-1` and fires `btn_long` exactly once per press.
- Outputs are registered; pulses are exactly one cycle wide. `btn_press`, `btn_release` and `btn_long` are mutually exclusive in any cycle.
- `resetn` low, at any time, including mid-count:
  - Immediately forces IDLE, `cnt=0`, long counter 0, all outputs 0.
  - Synchronizer flops go to the released level.
  - A button held through reset is reported as a fresh press after release of `resetn`, with no `btn_release` emitted.

## Timing
- Edge 0 is the first clock edge that captures a stable new raw level into synchronizer flop 1.
- `btn_press` / `btn_release` and the `btn_level` change register at edge `DEBOUNCE_CYCLES+2`.
- `btn_long` registers `LONG_CYCLES` edges after the `btn_press` edge, if still in PRESSED or RELEASE_WAIT.
- Any opposite sample during a WAIT state restarts qualification. Total latency resumes from the next edge 0.
- No throughput limit: a new press may start the cycle after `btn_release`.

## Configuration
- `BUTTON_DEBOUNCER_LONGPRESS_EN` defined: the long counter and `btn_long` logic are present, as described above.
- Not defined: the long counter is not instantiated; `btn_long` is tied 0; `LONG_CYCLES` is ignored and does not affect `CNT_W`.

## Structure
- Package `debounce_pkg`:
  - FSM state encoding (IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3).
  - Default cycle constants for 50 MHz.
- One sub-module `sync_ff2`: parameterized reset value, async active-low reset, 1-bit two-flop synchronizer. Reused for other board inputs.

## Test plan
Bench uses `DEBOUNCE_CYCLES=4`, `LONG_CYCLES=20`, `ACTIVE_LOW=1`.
- Clean press: hold `btn_raw` 1→0 at edge 0 → `btn_press` high for exactly one cycle registered at edge 6, `btn_level` 1 from edge 6.
- Bounce: toggle `btn_raw` 0/1 every 2 cycles for 20 cycles, then hold 0 → no pulse during bouncing; single `btn_press` 6 edges after the final stable edge.
- Release with bounce: from PRESSED, raw to 1 for 2 cycles, back to 0, then to 1 and hold → no `btn_release` on the glitch; one `btn_release` 6 edges after the final hold; `btn_level` returns to 0.
- Long press (macro on): hold pressed 40 cycles → `btn_long` exactly once, 20 edges after `btn_press`. Macro off: `btn_long` stays 0.
- Reset mid-op: assert `resetn` low during PRESS_WAIT with `cnt=2` → all outputs 0 asynchronously. Keep button held and release reset → `btn_press` 6+ edges later, no `btn_release` seen.
- Back-to-back: release then immediate re-press → `btn_release` and `btn_press` separated by ≥ 6 cycles, never in the same cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and 50 MHz default timing for the push-button debouncer.
// Long-press logic is built only with BUTTON_DEBOUNCER_LONGPRESS_EN.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_LONG_CYCLES     = 50000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for a single asynchronous board input.
// Both flops reset to RST_VAL so a released pin looks idle out of reset.
module sync_ff2 #(
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounced push-button: clean level plus press/release/long pulses.
// Long-press pulse is present only with BUTTON_DEBOUNCER_LONGPRESS_EN.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
  localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, LONG_CYCLES));
`else
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
`endif
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q;
  logic             s;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             level_d, press_d, release_d;

  sync_ff2 #(
    .RST_VAL(ACTIVE_LOW)
  ) u_sync (
    .clk   (clk),
    .resetn(resetn),
    .d     (btn_raw),
    .q     (sync_q)
  );

  assign s = ACTIVE_LOW ? ~sync_q : sync_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      btn_level   <= level_d;
      btn_press   <= press_d;
      btn_release <= release_d;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s)                 state_n = IDLE;
        else if (cnt == DB_LAST) state_n = PRESSED;
        else                    cnt_n   = cnt + 1'b1;
      end
      PRESSED: begin
        if (!s) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s)                  state_n = PRESSED;
        else if (cnt == DB_LAST) state_n = IDLE;
        else                    cnt_n   = cnt + 1'b1;
      end
    endcase
  end

  always_comb begin
    press_d   = (state == PRESS_WAIT) && (state_n == PRESSED);
    release_d = (state == RELEASE_WAIT) && (state_n == IDLE);
    level_d   = (state_n == PRESSED) || (state_n == RELEASE_WAIT);
  end

`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [CNT_W-1:0] lcnt;
  logic             ldone;
  logic             held;
  logic             long_d;

  assign held   = (state == PRESSED) || (state == RELEASE_WAIT);
  // a release edge wins so the three pulses never coincide
  assign long_d = held && !release_d && !ldone && (lcnt == LONG_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lcnt     <= '0;
      ldone    <= 1'b0;
      btn_long <= 1'b0;
    end else begin
      btn_long <= long_d;
      if (press_d) begin
        lcnt  <= '0;
        ldone <= 1'b0;
      end else if (held) begin
        if (lcnt != LONG_LAST) lcnt <= lcnt + 1'b1;
        if (long_d)            ldone <= 1'b1;
      end
    end
  end
`else
  assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with short debounce/long windows.
// Long-press expectations follow BUTTON_DEBOUNCER_LONGPRESS_EN.
module tb_button_debouncer;

`ifdef BUTTON_DEBOUNCER_LONGPRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  logic btn_raw;
  logic btn_level, btn_press, btn_release, btn_long;
  int   total = 0;
  int   bad   = 0;

  button_debouncer #(
    .ACTIVE_LOW     (1'b1),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic exp4(input string tag, input logic l, input logic p,
                      input logic r, input logic g);
    chk({tag, ".level"},   btn_level,   l);
    chk({tag, ".press"},   btn_press,   p);
    chk({tag, ".release"}, btn_release, r);
    chk({tag, ".long"},    btn_long,    g);
  endtask

  initial begin
    resetn  = 1'b0;
    btn_raw = 1'b1;
    repeat (3) step();
    exp4("reset", 0, 0, 0, 0);
    resetn = 1'b1;
    repeat (3) step();
    exp4("idle", 0, 0, 0, 0);

    // clean press, then hold for long-press window
    btn_raw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      exp4("clean_wait", 0, 0, 0, 0);
    end
    step();
    exp4("clean_press", 1, 1, 0, 0);
    for (int k = 1; k < 40; k++) begin
      step();
      exp4("hold", 1, 0, 0, LONG_ON && (k == 20));
    end

    // release with a two-cycle glitch first
    btn_raw = 1'b1;
    repeat (2) begin step(); exp4("rel_glitch", 1, 0, 0, 0); end
    btn_raw = 1'b0;
    repeat (4) begin step(); exp4("rel_back", 1, 0, 0, 0); end
    btn_raw = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp4("rel_wait", 1, 0, 0, 0);
    end
    step();
    exp4("rel_edge6", 0, 0, 1, 0);
    step();
    exp4("rel_after", 0, 0, 0, 0);

    // bouncing press
    repeat (5) begin
      btn_raw = 1'b0;
      repeat (2) begin step(); exp4("bounce", 0, 0, 0, 0); end
      btn_raw = 1'b1;
      repeat (2) begin step(); exp4("bounce", 0, 0, 0, 0); end
    end
    btn_raw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      exp4("bounce_wait", 0, 0, 0, 0);
    end
    step();
    exp4("bounce_press", 1, 1, 0, 0);

    // back-to-back release then press
    btn_raw = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp4("b2b_relwait", 1, 0, 0, 0);
    end
    step();
    exp4("b2b_release", 0, 0, 1, 0);
    btn_raw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      exp4("b2b_presswait", 0, 0, 0, 0);
    end
    step();
    exp4("b2b_press", 1, 1, 0, 0);

    // asynchronous reset while pressed, button held through it
    resetn = 1'b0;
    #2;
    exp4("async_rst", 0, 0, 0, 0);
    repeat (2) begin step(); exp4("in_rst", 0, 0, 0, 0); end
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp4("held_rst_wait", 0, 0, 0, 0);
    end
    step();
    exp4("held_rst_press", 1, 1, 0, 0);

    // reset during PRESS_WAIT with cnt=2
    btn_raw = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp4("pre_rel_wait", 1, 0, 0, 0);
    end
    step();
    exp4("pre_rel", 0, 0, 1, 0);
    btn_raw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      exp4("pw_cnt", 0, 0, 0, 0);
    end
    resetn = 1'b0;
    #2;
    exp4("pw_rst", 0, 0, 0, 0);
    repeat (2) step();
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp4("pw_rst_wait", 0, 0, 0, 0);
    end
    step();
    exp4("pw_rst_press", 1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
